// File: rtl/qgemm_exp_pkg.sv
// -----------------------------------------------------------------------------
// qgemm_exp_pkg
// Shared definitions for the exponent-max scheduling path of the quantised GEMM
// datapath.
//   sched_state_e : scheduler FSM states (IDLE, ACCUM, FLUSH, HOLD)
//   raw_max_norm  : largest raw exponent that still encodes a normal number,
//                   i.e. 2^exp_w - 2 (all-ones is reserved for Inf/NaN)
// -----------------------------------------------------------------------------
package qgemm_exp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HOLD  = 2'd3
  } sched_state_e;

  function automatic int raw_max_norm(input int exp_w);
    return (1 << exp_w) - 2;
  endfunction

endpackage : qgemm_exp_pkg

// File: rtl/exp_cross_product.sv
// -----------------------------------------------------------------------------
// exp_cross_product
// Combinational outer "product" of two raw exponent vectors. For each element
// (i, j) it forms e1[i] + e2[j] - FP_EXP_BIAS + bump[i*MAT_SIZE_2+j], clamped to
// [0, raw_max_norm(FP_EXP_W)]; any non-positive result becomes 0.
// Ports:
//   vec_1    in  FP_EXP_W*MAT_SIZE_1            raw row exponents
//   vec_2    in  FP_EXP_W*MAT_SIZE_2            raw column exponents
//   bump     in  MAT_SIZE_1*MAT_SIZE_2          mantissa-normalisation bumps
//   prod_exp out FP_EXP_W*MAT_SIZE_1*MAT_SIZE_2 clamped product exponents,
//                                               element i*MAT_SIZE_2+j
// -----------------------------------------------------------------------------
module exp_cross_product
  import qgemm_exp_pkg::*;
#(
  parameter int MAT_SIZE_1  = 16,
  parameter int MAT_SIZE_2  = 16,
  parameter int FP_EXP_W    = 8,
  parameter int FP_EXP_BIAS = 127
) (
  input  logic [FP_EXP_W*MAT_SIZE_1-1:0]            vec_1,
  input  logic [FP_EXP_W*MAT_SIZE_2-1:0]            vec_2,
  input  logic [MAT_SIZE_1*MAT_SIZE_2-1:0]          bump,
  output logic [FP_EXP_W*MAT_SIZE_1*MAT_SIZE_2-1:0] prod_exp
);

  localparam int RAW_MAX = raw_max_norm(FP_EXP_W);

  for (genvar i = 0; i < MAT_SIZE_1; i++) begin : g_row
    for (genvar j = 0; j < MAT_SIZE_2; j++) begin : g_col
      localparam int E = i * MAT_SIZE_2 + j;
      // Signed 32-bit sum so the bias subtraction can go negative before the clamp.
      int sum;
      assign sum = int'(vec_1[i*FP_EXP_W +: FP_EXP_W])
                 + int'(vec_2[j*FP_EXP_W +: FP_EXP_W])
                 - FP_EXP_BIAS
                 + int'(bump[E]);
      assign prod_exp[E*FP_EXP_W +: FP_EXP_W] =
          (sum <= 0)       ? '0 :
          (sum > RAW_MAX)  ? FP_EXP_W'(RAW_MAX) :
                             FP_EXP_W'(sum);
    end
  end

endmodule : exp_cross_product

// File: rtl/exp_max_scheduler.sv
// -----------------------------------------------------------------------------
// exp_max_scheduler
// Runs one job of num_k exponent beats: each accepted beat is staged for one
// cycle, expanded by exp_cross_product, and folded into a per-element running
// maximum. After the last beat drains (FLUSH) the matrix is offered on out_*.
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   start, num_k          job request; num_k beats (0 = ignored)
//   busy                  job in progress (state not IDLE)
//   in_valid / in_ready   beat handshake (ready only in ACCUM)
//   in_vec_1, in_vec_2    raw row / column exponents of the beat
//   in_bump               per-element normalisation bumps of the beat
//   out_valid / out_ready result handshake (valid only in HOLD)
//   out_max_exp           running-max raw exponent, element i*MAT_SIZE_2+j
// -----------------------------------------------------------------------------
module exp_max_scheduler
  import qgemm_exp_pkg::*;
#(
  parameter int MAT_SIZE_1  = 16,
  parameter int MAT_SIZE_2  = 16,
  parameter int FP_EXP_W    = 8,
  parameter int FP_EXP_BIAS = 127,
  parameter int K_CNT_W     = 8
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic [K_CNT_W-1:0]                        num_k,
  output logic                                      busy,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [FP_EXP_W*MAT_SIZE_1-1:0]            in_vec_1,
  input  logic [FP_EXP_W*MAT_SIZE_2-1:0]            in_vec_2,
  input  logic [MAT_SIZE_1*MAT_SIZE_2-1:0]          in_bump,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [FP_EXP_W*MAT_SIZE_1*MAT_SIZE_2-1:0] out_max_exp
);

  localparam int N_ELEM = MAT_SIZE_1 * MAT_SIZE_2;

  sched_state_e state_q, state_d;
  logic [K_CNT_W-1:0] num_k_q, num_k_d;
  logic [K_CNT_W-1:0] cnt_q, cnt_d;
  logic               s_valid_q;
  logic [FP_EXP_W*MAT_SIZE_1-1:0]   s_vec_1_q;
  logic [FP_EXP_W*MAT_SIZE_2-1:0]   s_vec_2_q;
  logic [N_ELEM-1:0]                s_bump_q;
  logic [FP_EXP_W*N_ELEM-1:0]       max_q, max_d;
  logic [FP_EXP_W*N_ELEM-1:0]       prod_exp;

  logic accept;
  logic job_start;
  logic last_beat;

  assign in_ready    = (state_q == ST_ACCUM);
  assign out_valid   = (state_q == ST_HOLD);
  assign busy        = (state_q != ST_IDLE);
  assign out_max_exp = max_q;

  assign accept    = in_valid && in_ready;
  assign job_start = (state_q == ST_IDLE) && start && (num_k != '0);
  assign last_beat = accept && (cnt_q == num_k_q - K_CNT_W'(1));

  // ---------------------------------------------------------------------------
  // Control FSM: next state, latched beat count and beat counter.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    num_k_d = num_k_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (job_start) begin
          num_k_d = num_k;
          cnt_d   = '0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (last_beat)   state_d = ST_FLUSH;
        else if (accept) cnt_d   = cnt_q + K_CNT_W'(1);
      end
      // The last beat is still in the stage register here; one cycle lets it
      // reach the max matrix before the result is offered.
      ST_FLUSH: state_d = ST_HOLD;
      ST_HOLD: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Cross-product datapath fed by the stage register.
  // ---------------------------------------------------------------------------
  exp_cross_product #(
    .MAT_SIZE_1  (MAT_SIZE_1),
    .MAT_SIZE_2  (MAT_SIZE_2),
    .FP_EXP_W    (FP_EXP_W),
    .FP_EXP_BIAS (FP_EXP_BIAS)
  ) u_cross (
    .vec_1    (s_vec_1_q),
    .vec_2    (s_vec_2_q),
    .bump     (s_bump_q),
    .prod_exp (prod_exp)
  );

  // Running maximum; a new job clears it, otherwise it is left untouched so the
  // last result stays readable after the handshake.
  always_comb begin
    max_d = max_q;
    if (job_start) begin
      max_d = '0;
    end else if (s_valid_q) begin
      for (int e = 0; e < N_ELEM; e++) begin
        if (prod_exp[e*FP_EXP_W +: FP_EXP_W] > max_q[e*FP_EXP_W +: FP_EXP_W])
          max_d[e*FP_EXP_W +: FP_EXP_W] = prod_exp[e*FP_EXP_W +: FP_EXP_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= ST_IDLE;
      num_k_q   <= '0;
      cnt_q     <= '0;
      s_valid_q <= 1'b0;
      max_q     <= '0;
    end else begin
      state_q   <= state_d;
      num_k_q   <= num_k_d;
      cnt_q     <= cnt_d;
      s_valid_q <= accept;
      max_q     <= max_d;
    end
  end

  // NOTE: stage payload carries no reset; it is only consumed while s_valid_q
  // is set, and s_valid_q itself is reset, so a beat in flight at reset is
  // discarded without clearing the wide data.
  always_ff @(posedge clk) begin
    if (accept) begin
      s_vec_1_q <= in_vec_1;
      s_vec_2_q <= in_vec_2;
      s_bump_q  <= in_bump;
    end
  end

endmodule : exp_max_scheduler

// File: doc/exp_max_scheduler.md
EXP_MAX_SCHEDULER -- requirements
Module: exp_max_scheduler

Interface
REQ-001 SHALL have parameter MAT_SIZE_1, default 16, row count of the exponent tile.
REQ-002 SHALL have parameter MAT_SIZE_2, default 16, column count of the exponent tile.
REQ-003 SHALL have parameter FP_EXP_W, default 8, raw exponent width.
REQ-004 SHALL have parameter FP_EXP_BIAS, default 127, exponent bias.
REQ-005 SHALL have parameter K_CNT_W, default 8, width of the k-beat count.
REQ-006 SHALL use one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-007 SHALL have ports:
- start input 1: job request.
- num_k input K_CNT_W: beats per job, sampled with start.
- busy output 1: job in progress (state not IDLE).
- in_valid input 1 / in_ready output 1: beat handshake.
- in_vec_1 input FP_EXP_W*MAT_SIZE_1: raw row exponents.
- in_vec_2 input FP_EXP_W*MAT_SIZE_2: raw column exponents.
- in_bump input MAT_SIZE_1*MAT_SIZE_2: mantissa-normalisation bumps.
- out_valid output 1 / out_ready input 1: result handshake.
- out_max_exp output FP_EXP_W*MAT_SIZE_1*MAT_SIZE_2: per-element running-max raw exponent, element i*MAT_SIZE_2+j.

Function
REQ-008 SHALL implement FSM IDLE, ACCUM, FLUSH, HOLD.
REQ-009 In IDLE, start=1 with num_k!=0 SHALL latch num_k, clear the max matrix to 0 and the beat counter to 0, and go to ACCUM; start with num_k=0 SHALL be ignored.
REQ-010 start outside IDLE SHALL be ignored.
REQ-011 in_ready SHALL be 1 only in ACCUM; a beat is accepted on in_valid&&in_ready.
REQ-012 An accepted beat SHALL be registered into one stage register (vectors, bumps, s_valid=1); s_valid SHALL clear on any non-accept cycle.
REQ-013 Stage outputs SHALL feed the cross-product datapath, computing per element e1+e2-FP_EXP_BIAS+bump, saturated to [0, 2^FP_EXP_W-2], with <=0 giving 0.
REQ-014 When s_valid=1, each max element SHALL update to the unsigned max of its current value and the product exponent on the next edge.
REQ-015 Acceptance of beat num_k (counter = num_k-1) SHALL move ACCUM to FLUSH; FLUSH SHALL last exactly one cycle and then go to HOLD.
REQ-016 out_valid SHALL be 1 exactly in HOLD, asserted 2 cycles after the last accept cycle; out_max_exp SHALL hold stable while out_valid&&!out_ready.
REQ-017 out_valid&&out_ready SHALL return to IDLE; out_max_exp SHALL retain its last value until the next job start clears it.
REQ-018 in_valid gaps in ACCUM SHALL stall the counter with no max change.

Reset
REQ-019 rst SHALL force state IDLE, busy=0, in_ready=0, out_valid=0, s_valid=0, counter=0 and out_max_exp all zeros, in any state.
REQ-020 An in-flight stage beat at rst SHALL be discarded; the first job after reset SHALL be unaffected.

Structure
REQ-021 Shared package qgemm_exp_pkg SHALL hold the FSM state enum and the RAW_MAX_NORM constant function (2^FP_EXP_W-2).
REQ-022 The existing exp_cross_product block SHALL be instantiated once as the sole sub-module; max/compare logic stays in this module.

Verification
REQ-023 Scenario 1: num_k=1, all e1=e2=127, bump=0 -> all outputs 127, out_valid 2 cycles after accept.
REQ-024 Scenario 2: num_k=3, beats e1=e2=130, then 120, then 140, bump=0 -> all outputs 153; bump=1 on element 0 of beat 3 only -> element 0 is 154.
REQ-025 Scenario 3: e1=e2=255 -> 254; a job of only e1=e2=1 -> all 0.
REQ-026 Scenario 4: num_k=4 with in_valid gaps and out_ready low 5 cycles in HOLD -> counter stalls, out_max_exp stable, in_ready=0, start ignored during HOLD.
REQ-027 Scenario 5: rst after 2 of 4 beats -> next cycle busy=0 and out_valid=0; a following num_k=1 job with e1=e2=128 -> all 129.
REQ-028 Scenario 6: start with num_k=0 -> busy stays 0, no out_valid.
